// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution front end.
package conv_pkg;

    localparam int ELEM_XLEN = 16;
    localparam int MAX_WIDTH = 1024;

    typedef logic [ELEM_XLEN-1:0] elem_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Bits needed to hold a count from 0 to width inclusive.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

    // Keep vector for a frame closed on beat bi: bit e is set when element e
    // carries real data, cleared where padding goes.
    function automatic logic [MAX_WIDTH-1:0] mask(input int bi, input int lanes, input int width);
        logic [MAX_WIDTH-1:0] m;
        m = '0;
        for (int e = 0; e < MAX_WIDTH; e++)
            m[e] = (e < (bi + 1) * lanes) && (e < width);
        return m;
    endfunction

endpackage

// File: rtl/stream_frame_buffer.sv
// Collector for one frame: beat index, lane write steering and padding merge.
module stream_frame_buffer
    import conv_pkg::*;
#(
    parameter int XLEN = 16,
    parameter int WIDTH = 128,
    parameter int LANES = 1,
    parameter logic [XLEN-1:0] PAD_VALUE = '0,
    localparam int BEATS = WIDTH / LANES,
    localparam int BI_W = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int CW = count_width(WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fire,
    input  logic [LANES-1:0][XLEN-1:0]   s_data,
    input  logic                         s_last,
    output logic                         complete,
    output logic [CW-1:0]                beat_count,
    output logic                         beat_padded,
    output logic [WIDTH-1:0][XLEN-1:0]   merged,
    output logic [WIDTH-1:0][XLEN-1:0]   collector
);

    logic [BI_W-1:0]  bi;
    logic             at_end;
    logic [WIDTH-1:0] keep;

    assign at_end      = (int'(bi) == BEATS - 1);
    assign complete    = fire && (at_end || s_last);
    assign beat_count  = CW'((int'(bi) + 1) * LANES);
    assign beat_padded = s_last && !at_end;
    assign keep        = WIDTH'(mask(int'(bi), LANES, WIDTH));

    // Collector overlaid with the current beat; on an early close everything
    // past the current beat becomes PAD_VALUE so stale data cannot escape.
    always_comb begin
        merged = collector;
        for (int e = 0; e < WIDTH; e++) begin
            if (e / LANES == int'(bi))
                merged[e] = s_data[e % LANES];
            else if (s_last && !keep[e])
                merged[e] = PAD_VALUE;
        end
    end

    // Every accepted beat commits the merged view and advances the beat index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bi        <= '0;
            collector <= '0;
        end else if (fire) begin
            collector <= merged;
            bi        <= complete ? '0 : bi + 1'b1;
        end
    end

endmodule

// File: rtl/stream_to_parallel.sv
// Gathers LANES-wide input beats into WIDTH-element vectors with valid/ready
// on both sides; collector plus output register give full-rate streaming.
module stream_to_parallel
    import conv_pkg::*;
#(
    parameter int XLEN = 16,
    parameter int WIDTH = 128,
    parameter int LANES = 1,
    parameter logic [XLEN-1:0] PAD_VALUE = '0,
    localparam int CW = count_width(WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [LANES-1:0][XLEN-1:0]   s_data,
    input  logic                         s_last,
    output logic                         p_valid,
    input  logic                         p_ready,
    output logic [WIDTH-1:0][XLEN-1:0]   p_data,
    output logic [CW-1:0]                p_count,
    output logic                         p_padded,
    output logic [31:0]                  frame_cnt
);

    if (WIDTH % LANES != 0) begin : g_bad_lanes
        $error("stream_to_parallel: WIDTH must be a multiple of LANES");
    end
    if (WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("stream_to_parallel: WIDTH exceeds conv_pkg::MAX_WIDTH");
    end

    state_t                     state;
    logic [CW-1:0]              held_count;
    logic                       held_padded;
    logic                       fire, p_hs, slot_free;
    logic                       complete, beat_padded;
    logic [CW-1:0]              beat_count;
    logic [WIDTH-1:0][XLEN-1:0] merged, collector;

    assign fire      = s_valid && s_ready;
    assign p_hs      = p_valid && p_ready;
    assign slot_free = !p_valid || p_ready;

    stream_frame_buffer #(
        .XLEN(XLEN), .WIDTH(WIDTH), .LANES(LANES), .PAD_VALUE(PAD_VALUE)
    ) u_buf (
        .clk(clk), .rst(rst), .fire(fire), .s_data(s_data), .s_last(s_last),
        .complete(complete), .beat_count(beat_count), .beat_padded(beat_padded),
        .merged(merged), .collector(collector)
    );

    // FILL/HOLD control, output register and delivered-frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FILL;
            s_ready     <= 1'b1;
            p_valid     <= 1'b0;
            p_data      <= '0;
            p_count     <= '0;
            p_padded    <= 1'b0;
            held_count  <= '0;
            held_padded <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            if (p_hs) begin
                frame_cnt <= frame_cnt + 32'd1;
                p_valid   <= 1'b0;  // overridden below when a new frame loads
            end
            case (state)
                FILL: begin
                    if (complete) begin
                        if (slot_free) begin
                            p_data   <= merged;
                            p_count  <= beat_count;
                            p_padded <= beat_padded;
                            p_valid  <= 1'b1;
                        end else begin
                            // Frame parks in the collector until the output drains.
                            held_count  <= beat_count;
                            held_padded <= beat_padded;
                            state       <= HOLD;
                            s_ready     <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (p_hs) begin
                        p_data   <= collector;
                        p_count  <= held_count;
                        p_padded <= held_padded;
                        p_valid  <= 1'b1;
                        state    <= FILL;
                        s_ready  <= 1'b1;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule
